// File: rtl/risc8_fetch_seq.sv
// Purpose : risc8 fetch sequencer. It fetches a variable-length instruction and holds it for the
//           datapath. It also arbitrates the single-port memory between fetch and datapath
//           load/store.
// Latency : the instruction is valid 2+2n cycles after the opcode request (n = opcode[7:6]).
//           A data write completes (dack) in its issue cycle. A data read completes one cycle
//           after issue.
// Backpr. : an instruction is held (instr_valid) until instr_ack. A data request (dreq) waits,
//           with no memory activity, until HOLD. In HOLD a data request beats instr_ack.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata : shared single-port memory, read latency 1
//   instr, imm0..imm2, instr_pc   : held opcode, immediates, opcode address
//   instr_valid / instr_ack       : held-instruction handshake
//   pc_load, pc_new               : redirect, taken only with an accepted instr_ack
//   dreq/dwr/daddr/dwdata         : datapath data access request
//   dack/drdata                   : data access completion pulse, read data

module risc8_fetch_seq #(
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    // shared memory port
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    // held instruction
    output logic [7:0]      instr,
    output logic [7:0]      imm0,
    output logic [7:0]      imm1,
    output logic [7:0]      imm2,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ack,
    // redirect
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_new,
    // datapath data access
    input  logic            dreq,
    input  logic            dwr,
    input  logic [PC_W-1:0] daddr,
    input  logic [7:0]      dwdata,
    output logic            dack,
    output logic [7:0]      drdata
);

    typedef enum logic [2:0] {
        OP_REQ   = 3'd0,
        OP_CAP   = 3'd1,
        IMM_REQ  = 3'd2,
        IMM_CAP  = 3'd3,
        HOLD     = 3'd4,
        DATA_CAP = 3'd5
    } state_t;

    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [1:0]      imm_n;    // immediates this opcode carries
    logic [1:0]      imm_idx;  // next immediate slot to fill

    // Sequencing and held-instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OP_REQ;
            pc       <= PC_INIT;
            instr    <= 8'd0;
            imm0     <= 8'd0;
            imm1     <= 8'd0;
            imm2     <= 8'd0;
            instr_pc <= '0;
            imm_n    <= 2'd0;
            imm_idx  <= 2'd0;
        end else begin
            case (state)
                OP_REQ: begin
                    instr_pc <= pc;
                    pc       <= pc + 1'b1;   // wraps naturally at PC_W bits
                    state    <= OP_CAP;
                end
                OP_CAP: begin
                    instr   <= mem_rdata;
                    imm0    <= 8'd0;
                    imm1    <= 8'd0;
                    imm2    <= 8'd0;
                    imm_n   <= mem_rdata[7:6];
                    imm_idx <= 2'd0;
                    state   <= (mem_rdata[7:6] == 2'd0) ? HOLD : IMM_REQ;
                end
                IMM_REQ: begin
                    pc    <= pc + 1'b1;
                    state <= IMM_CAP;
                end
                IMM_CAP: begin
                    case (imm_idx)
                        2'd0:    imm0 <= mem_rdata;
                        2'd1:    imm1 <= mem_rdata;
                        default: imm2 <= mem_rdata;
                    endcase
                    imm_idx <= imm_idx + 2'd1;
                    // imm_idx never exceeds 2, so imm_idx+1 fits in two bits
                    state   <= (imm_idx + 2'd1 == imm_n) ? HOLD : IMM_REQ;
                end
                HOLD: begin
                    // A pending data access takes the memory. The ack must come again later.
                    if (dreq) begin
                        if (!dwr) begin
                            state <= DATA_CAP;
                        end
                    end else if (instr_ack) begin
                        if (pc_load) begin
                            pc <= pc_new;
                        end
                        state <= OP_REQ;
                    end
                end
                DATA_CAP: begin
                    state <= HOLD;
                end
                default: begin
                    state <= OP_REQ;
                end
            endcase
        end
    end

    // Memory port and handshake outputs decode from state. During HOLD they also follow the
    // live data request, so a write completes in its issue cycle. All outputs are forced
    // quiet while reset is high.
    always_comb begin
        mem_addr    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_wdata   = 8'd0;
        instr_valid = 1'b0;
        dack        = 1'b0;
        drdata      = 8'd0;
        if (!rst) begin
            case (state)
                OP_REQ, IMM_REQ: begin
                    mem_addr = pc;
                    mem_rd   = 1'b1;
                end
                HOLD: begin
                    instr_valid = 1'b1;
                    if (dreq) begin
                        mem_addr  = daddr;
                        mem_wr    = dwr;
                        mem_rd    = ~dwr;
                        mem_wdata = dwdata;
                        dack      = dwr;
                    end
                end
                DATA_CAP: begin
                    dack   = 1'b1;
                    drdata = mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc8_fetch_seq.sv
// Testbench for risc8_fetch_seq. It provides a behavioural single-port memory with one-cycle
// read latency. A reference model predicts each instruction from memory contents
// (opcode[7:6] = number of immediates). The model also predicts latency, data-access results
// and pc wrap.

`define CHK(tag, o, e) check(tag, 32'(o), 32'(e))

module tb_risc8_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr, imm0, imm1, imm2;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        dreq, dwr;
    logic [15:0] daddr;
    logic [7:0]  dwdata;
    logic        dack;
    logic [7:0]  drdata;

    risc8_fetch_seq #(.PC_W(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .instr(instr), .imm0(imm0), .imm1(imm1), .imm2(imm2),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .pc_load(pc_load), .pc_new(pc_new),
        .dreq(dreq), .dwr(dwr), .daddr(daddr), .dwdata(dwdata),
        .dack(dack), .drdata(drdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    int          vectors = 0;
    int          miscompares = 0;
    // Expected held instruction, kept for checks made during data accesses
    logic [7:0]  e_instr;
    logic [7:0]  e_imm [3];
    logic [15:0] e_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock. Captures memory-port outputs before the edge and applies them to the
    // memory model after it. Returns at the next falling edge.
    task automatic tick();
        logic        rd, wr;
        logic [15:0] a;
        logic [7:0]  wd;
        rd = mem_rd; wr = mem_wr; a = mem_addr; wd = mem_wdata;
        `CHK("rd_wr_exclusive", rd & wr, 1'b0);
        @(posedge clk);
        #1;
        if (wr) mem[a] = wd;
        if (rd) mem_rdata = mem[a];
        else    mem_rdata = 8'($urandom);   // garbage when no read was issued
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_ack = 1'b0; pc_load = 1'b0; pc_new = 16'd0;
        dreq = 1'b0; dwr = 1'b0; daddr = 16'd0; dwdata = 8'd0;
    endtask

    task automatic check_held(input string tag);
        `CHK({tag, "_instr"}, instr, e_instr);
        `CHK({tag, "_imm0"}, imm0, e_imm[0]);
        `CHK({tag, "_imm1"}, imm1, e_imm[1]);
        `CHK({tag, "_imm2"}, imm2, e_imm[2]);
        `CHK({tag, "_instr_pc"}, instr_pc, e_pc);
    endtask

    // Entered with the DUT in OP_REQ. Fetches one instruction and checks it.
    // A data write stays pending throughout and must not be served.
    task automatic do_fetch(input logic [15:0] pc0, output logic [15:0] pc_next);
        int n;
        int cyc;
        logic [15:0] a;
        e_instr = mem[pc0];
        n = int'(e_instr[7:6]);
        for (int i = 0; i < 3; i++) begin
            a = pc0 + 16'(i + 1);
            e_imm[i] = (i < n) ? mem[a] : 8'd0;
        end
        e_pc = pc0;
        idle_inputs();
        dreq = 1'($urandom);
        dwr = 1'b1; daddr = pc0; dwdata = 8'($urandom);
        #1;
        `CHK("op_req_rd", mem_rd, 1'b1);
        `CHK("op_req_addr", mem_addr, pc0);
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < 20) begin
            `CHK("fetch_no_data_wr", mem_wr, 1'b0);
            `CHK("fetch_no_dack", dack, 1'b0);
            tick();
            cyc++;
        end
        `CHK("fetch_latency", cyc, 2 + 2 * n);
        check_held("fetch");
        dreq = 1'b0;
        pc_next = pc0 + 16'(1 + n);
    endtask

    task automatic do_read(input logic [15:0] a);
        logic [7:0] exp_d;
        exp_d = mem[a];
        dreq = 1'b1; dwr = 1'b0; daddr = a;
        instr_ack = 1'($urandom); pc_load = 1'b1; pc_new = 16'($urandom);
        #1;
        `CHK("rd_issue_rd", mem_rd, 1'b1);
        `CHK("rd_issue_addr", mem_addr, a);
        `CHK("rd_issue_nodack", dack, 1'b0);
        `CHK("rd_issue_valid", instr_valid, 1'b1);
        tick();
        idle_inputs();
        #1;
        `CHK("rd_cap_dack", dack, 1'b1);
        `CHK("rd_cap_data", drdata, exp_d);
        `CHK("rd_cap_valid", instr_valid, 1'b0);
        `CHK("rd_cap_nomem", mem_rd | mem_wr, 1'b0);
        check_held("rd_cap");
        tick();
        `CHK("rd_back_hold", instr_valid, 1'b1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic ack);
        dreq = 1'b1; dwr = 1'b1; daddr = a; dwdata = d; instr_ack = ack;
        pc_load = ack; pc_new = 16'($urandom);
        #1;
        `CHK("wr_mem_wr", mem_wr, 1'b1);
        `CHK("wr_mem_rd", mem_rd, 1'b0);
        `CHK("wr_addr", mem_addr, a);
        `CHK("wr_data", mem_wdata, d);
        `CHK("wr_dack", dack, 1'b1);
        tick();
        idle_inputs();
        #1;
        `CHK("wr_stays_hold", instr_valid, 1'b1);
    endtask

    task automatic hold_ops(input int k);
        for (int i = 0; i < k; i++) begin
            case ($urandom_range(0, 2))
                0: do_read(16'($urandom));
                1: do_write(16'($urandom), 8'($urandom), 1'($urandom));
                default: begin
                    idle_inputs();
                    pc_load = 1'b1; pc_new = 16'($urandom);   // no ack: redirect ignored
                    #1;
                    `CHK("idle_valid", instr_valid, 1'b1);
                    `CHK("idle_nomem", mem_rd | mem_wr, 1'b0);
                    tick();
                    idle_inputs();
                    #1;
                    `CHK("idle_still_hold", instr_valid, 1'b1);
                end
            endcase
        end
    endtask

    task automatic accept(input logic load, input logic [15:0] newpc);
        idle_inputs();
        instr_ack = 1'b1; pc_load = load; pc_new = newpc;
        #1;
        `CHK("ack_valid", instr_valid, 1'b1);
        tick();
        idle_inputs();
    endtask

    initial begin
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        ld;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h05;
        mem[4] = 8'hC1; mem[5] = 8'hAA; mem[6] = 8'hBB; mem[7] = 8'hCC;
        mem[16'h0100] = 8'h5A;
        mem_rdata = 8'd0;
        idle_inputs();
        rst = 1'b1;
        dreq = 1'b1; dwr = 1'b1;      // a request under reset must do nothing
        @(negedge clk);
        tick();
        tick();
        #1;
        `CHK("rst_mem_rd", mem_rd, 1'b0);
        `CHK("rst_mem_wr", mem_wr, 1'b0);
        `CHK("rst_mem_addr", mem_addr, 16'd0);
        `CHK("rst_valid", instr_valid, 1'b0);
        `CHK("rst_dack", dack, 1'b0);
        `CHK("rst_instr", instr, 8'd0);
        `CHK("rst_instr_pc", instr_pc, 16'd0);
        rst = 1'b0;

        // First fetch from the reset pc, then pc=4 with three immediates
        do_fetch(16'd0, pc);
        hold_ops(4);
        do_write(16'h0200, 8'h33, 1'b1);   // ack in the same cycle is ignored
        `CHK("wr_committed", mem[16'h0200], 8'h33);
        vectors++;
        if (mem[16'h0200] !== 8'h33) begin
            miscompares++;
            $error("FAIL wr_committed_direct: observed %0h", mem[16'h0200]);
        end
        accept(1'b1, 16'd4);
        do_fetch(16'd4, pc);
        do_read(16'h0100);
        accept(1'b0, 16'h0000);
        do_fetch(pc, pc);                  // next fetch address must be 8
        `CHK("after_c1_pc", e_pc, 16'd8);
        vectors++;
        if (instr_pc !== 16'd8) begin
            miscompares++;
            $error("FAIL after_c1_ipc: observed %0h", instr_pc);
        end

        // Wrap across the top of the address space
        mem[16'hFFFF] = 8'h40;
        mem[16'h0000] = 8'h77;
        accept(1'b1, 16'hFFFF);
        do_fetch(16'hFFFF, pc);
        vectors++;
        if (imm0 !== 8'h77) begin
            miscompares++;
            $error("FAIL wrap_imm0: observed %0h", imm0);
        end
        accept(1'b0, 16'h0000);
        do_fetch(pc, pc);                  // must start at 0x0001
        accept(1'b1, 16'h1234);
        do_fetch(16'h1234, pc);
        vectors++;
        if (instr_pc !== 16'h1234) begin
            miscompares++;
            $error("FAIL redirect_ipc: observed %0h", instr_pc);
        end

        // Randomized instruction stream with interleaved data accesses
        for (int i = 0; i < 40; i++) begin
            hold_ops($urandom_range(0, 4));
            ld = ($urandom_range(0, 3) == 0);
            tgt = 16'($urandom);
            accept(ld, tgt);
            do_fetch(ld ? tgt : pc, pc);
            vectors++;
            if (instr_valid !== 1'b1) begin
                miscompares++;
                $error("FAIL rand_valid: observed %0b", instr_valid);
            end
            vectors++;
            if (instr_pc !== e_pc) begin
                miscompares++;
                $error("FAIL rand_ipc: observed %0h expected %0h", instr_pc, e_pc);
            end
            vectors++;
            if (instr !== e_instr) begin
                miscompares++;
                $error("FAIL rand_instr: observed %0h expected %0h", instr, e_instr);
            end
        end

        // Reset during IMM_CAP abandons the fetch
        mem[16'h3000] = 8'hC0;
        accept(1'b1, 16'h3000);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        `CHK("rst_imm_valid", instr_valid, 1'b0);
        `CHK("rst_imm_rd", mem_rd, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        `CHK("rst_imm_instr", instr, 8'd0);
        `CHK("rst_imm_imm0", imm0, 8'd0);
        `CHK("rst_imm_imm1", imm1, 8'd0);
        `CHK("rst_imm_imm2", imm2, 8'd0);
        `CHK("rst_imm_ipc", instr_pc, 16'd0);
        do_fetch(16'd0, pc);

        // Reset during DATA_CAP drops the completion
        dreq = 1'b1; dwr = 1'b0; daddr = 16'h0100;
        #1;
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        `CHK("rst_dcap_dack", dack, 1'b0);
        tick();
        rst = 1'b0;
        do_fetch(16'd0, pc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/risc8_fetch_seq.md
RISC8_FETCH_SEQ -- requirements
Module: risc8_fetch_seq

Interface
REQ-001 Parameter PC_W, default 16, width of program counter and memory address.
REQ-002 Parameter RESET_PC, default 0, opcode address fetched first after reset.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  output  PC_W  shared single-port memory address.
REQ-006 mem_rd  output  1  memory read strobe; mem_rdata valid in the following cycle.
REQ-007 mem_wr  output  1  memory write strobe; write commits at the clock edge that samples it.
REQ-008 mem_wdata  output  8  memory write data.
REQ-009 mem_rdata  input  8  memory read data, one-cycle latency after mem_rd.
REQ-010 instr, imm0, imm1, imm2  output  8 each  held opcode and immediate bytes.
REQ-011 instr_pc  output  PC_W  opcode address of the held instruction.
REQ-012 instr_valid  output  1  instr/imm*/instr_pc are valid and stable.
REQ-013 instr_ack  input  1  datapath consumed held instruction.
REQ-014 pc_load, pc_new  input  1, PC_W  redirect: next opcode fetched from pc_new.
REQ-015 dreq, dwr, daddr, dwdata  input  1, 1, PC_W, 8  datapath data access request: write if dwr, else read.
REQ-016 dack  output  1  one-cycle completion pulse for a data access.
REQ-017 drdata  output  8  read data, valid only while dack is high after a read.

Function
REQ-018 Single-port memory SHALL be shared between instruction fetch and datapath data access; mem_rd and mem_wr SHALL never be high together.
REQ-019 States SHALL be OP_REQ, OP_CAP, IMM_REQ, IMM_CAP, HOLD, DATA_CAP.
REQ-020 OP_REQ: mem_addr=pc, mem_rd=1, instr_pc<=pc, pc<=pc+1; then OP_CAP.
REQ-021 OP_CAP: instr<=mem_rdata, imm0..imm2<=0, imm count n<=mem_rdata[7:6] (0..3), index<=0; n=0 -> HOLD, else IMM_REQ.
REQ-022 IMM_REQ: mem_addr=pc, mem_rd=1, pc<=pc+1; then IMM_CAP.
REQ-023 IMM_CAP: imm[index]<=mem_rdata, index<=index+1; index+1=n -> HOLD, else IMM_REQ.
REQ-024 Fetch latency SHALL be 2+2n cycles from OP_REQ entry to HOLD entry; instr_valid=1 exactly while in HOLD.
REQ-025 pc SHALL wrap modulo 2^PC_W (all-ones + 1 = 0), including mid-instruction.
REQ-026 HOLD, dreq=1: issue mem_addr=daddr, mem_wr=dwr, mem_rd=~dwr, mem_wdata=dwdata; write -> dack=1 same cycle, stay in HOLD; read -> DATA_CAP.
REQ-027 DATA_CAP: dack=1, drdata=mem_rdata; return to HOLD; instr_valid stays 0 in DATA_CAP and held outputs unchanged.
REQ-028 dreq SHALL be served only in HOLD; outside HOLD it is held pending with no memory activity for it.
REQ-029 HOLD, instr_ack=1, dreq=0: if pc_load, pc<=pc_new; go to OP_REQ next cycle.
REQ-030 HOLD with dreq=1 and instr_ack=1: data access wins; instr_ack ignored that cycle and must be re-presented.
REQ-031 pc_load SHALL be honored only together with an accepted instr_ack; otherwise ignored.
REQ-032 Back-to-back data accesses allowed: write each HOLD cycle; read every 2 cycles.

Reset
REQ-033 While rst=1: state<=OP_REQ, pc<=RESET_PC, instr/imm*/instr_pc<=0; mem_rd, mem_wr, dack, instr_valid=0 and mem_addr=0 combinationally.
REQ-034 rst mid-fetch or mid-DATA_CAP SHALL abandon the access: no dack, no instr_valid; first post-reset cycle is OP_REQ at RESET_PC.

Verification
REQ-035 Reset, mem[0]=0x05 -> OP_REQ addr 0 at cycle 0, instr_valid at cycle 2 with instr=0x05, imm*=0, instr_pc=0.
REQ-036 mem[4..7]=C1,AA,BB,CC from pc=4 -> instr=C1, imm0=AA, imm1=BB, imm2=CC, valid 8 cycles after OP_REQ, next opcode fetched at 8.
REQ-037 HOLD, read daddr=0x0100 holding 0x5A -> mem_rd one cycle, dack next cycle with drdata=0x5A; instr_valid low during DATA_CAP only.
REQ-038 HOLD, dreq write 0x33 to 0x0200 and instr_ack same cycle -> write with dack that cycle, no fetch; ack next cycle starts fetch.
REQ-039 pc=0xFFFF, opcode 0x40 at 0xFFFF, imm 0x77 at 0x0000 -> imm0=0x77, next fetch at 0x0001; instr_ack with pc_load, pc_new=0x1234 -> OP_REQ addr 0x1234.
REQ-040 rst asserted during IMM_CAP -> no instr_valid; fetch restarts at RESET_PC, all held outputs 0.
